// File: rtl/rst_seq.sv
// rst_seq: power-on / soft reset sequencer.
// A SYNC_STAGES-flop synchronizer qualifies release of the async power-on
// reset. The outputs are then held in reset for STRETCH cycles and released
// one at a time, GAP cycles apart, lowest index first. A soft request
// (sw_rst_req) in RELEASE or RUN restarts the sequence and is counted in
// sw_cnt, which saturates at 255.
// Optional feature: define RST_SEQ_DEBOUNCE_EN to require DEB_LEN
// consecutive high samples before a soft request is accepted.
module rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned GAP         = 4,
  parameter int unsigned DEB_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_rst_req,
  output logic [2:0] rst_out,
  output logic       done,
  output logic [1:0] rst_cause,
  output logic [7:0] sw_cnt
);

  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) &&
                          (STRETCH >= 1) && (STRETCH <= 255) &&
                          (GAP >= 1) && (GAP <= 255) &&
                          (DEB_LEN >= 2) && (DEB_LEN <= 15);

  generate
    if (!CFG_OK) begin : g_cfg_bad
      $error("rst_seq: parameter out of legal range");
    end
  endgenerate

  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH - 1);
  localparam logic [7:0] GAP_LAST     = 8'(GAP - 1);
  localparam logic [1:0] CAUSE_POR    = 2'b01;
  localparam logic [1:0] CAUSE_SOFT   = 2'b10;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [2:0]             rst_out_nxt;
  logic                   done_nxt;
  logic [1:0]             cause_nxt;
  logic [7:0]             sw_cnt_nxt;
  logic                   armed, armed_nxt;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   rst_ok;
  logic                   req_q;
  logic                   accept;

  // Reset-release synchronizer: asserts immediately, releases after SYNC_STAGES edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_ff <= '0;
    else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_ok = sync_ff[SYNC_STAGES-1];

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEB_LEN - 1);
  logic [3:0] deb_cnt;

  // Count consecutive high samples of the request; any low sample clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 deb_cnt <= '0;
    else if (!sw_rst_req)       deb_cnt <= '0;
    else if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + 4'd1;
  end

  // Qualified once DEB_LEN-1 prior highs are stored and the current sample is high.
  always_comb begin
    req_q = sw_rst_req && (deb_cnt == DEB_LAST);
  end
`else
  // Every high sample qualifies.
  always_comb begin
    req_q = sw_rst_req;
  end
`endif

  // A qualified request is taken once per high period, only outside ASSERT.
  always_comb begin
    accept = req_q && armed && (state != ASSERT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      rst_out   <= '1;
      done      <= 1'b0;
      rst_cause <= CAUSE_POR;
      sw_cnt    <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_out   <= rst_out_nxt;
      done      <= done_nxt;
      rst_cause <= cause_nxt;
      sw_cnt    <= sw_cnt_nxt;
      armed     <= armed_nxt;
    end
  end

  // Next-state and next-output logic; an accepted soft request overrides all.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rst_out_nxt = rst_out;
    done_nxt    = done;
    cause_nxt   = rst_cause;
    sw_cnt_nxt  = sw_cnt;
    armed_nxt   = armed;

    // A low sample re-arms acceptance for the next request.
    if (!sw_rst_req) armed_nxt = 1'b1;

    unique case (state)
      ASSERT: begin
        rst_out_nxt = '1;
        done_nxt    = 1'b0;
        if (!rst_ok || sw_rst_req) begin
          cnt_nxt = '0;
        end else if (cnt == STRETCH_LAST) begin
          state_nxt   = RELEASE;
          cnt_nxt     = '0;
          rst_out_nxt = 3'b110;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RELEASE: begin
        done_nxt = 1'b0;
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          // rst_out[1] still high means the first gap is in progress.
          if (rst_out[1]) begin
            rst_out_nxt = 3'b100;
          end else begin
            rst_out_nxt = 3'b000;
            done_nxt    = 1'b1;
            state_nxt   = RUN;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RUN: begin
        rst_out_nxt = 3'b000;
        done_nxt    = 1'b1;
        cnt_nxt     = '0;
      end
      default: begin
        state_nxt   = ASSERT;
        cnt_nxt     = '0;
        rst_out_nxt = '1;
        done_nxt    = 1'b0;
      end
    endcase

    if (accept) begin
      state_nxt   = ASSERT;
      cnt_nxt     = '0;
      rst_out_nxt = '1;
      done_nxt    = 1'b0;
      cause_nxt   = CAUSE_SOFT;
      armed_nxt   = 1'b0;
      if (sw_cnt != 8'hFF) sw_cnt_nxt = sw_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed, table-driven checks of the rst_seq release timeline,
// soft requests, held requests, sw_cnt saturation and async reset.
module tb_rst_seq;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int REQ_LEN = 4;
`else
  localparam int REQ_LEN = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [2:0] rst_out;
  logic       done;
  logic [1:0] rst_cause;
  logic [7:0] sw_cnt;

  rst_seq #(.SYNC_STAGES(2), .STRETCH(16), .GAP(4), .DEB_LEN(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .done       (done),
    .rst_cause  (rst_cause),
    .sw_cnt     (sw_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;   // edge offset relative to the first rst_out[0] fall
    logic [2:0] ro;
    logic       dn;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pos   = 0;
  int   exp_swc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, pos);
    end
  endtask

  // Walk the release timeline whose first fall is at edge 'fall'.
  task automatic play(input string tag, input int fall, input logic [1:0] cause, input int swc);
    for (int i = 0; i < 7; i++) begin
      while (pos < fall + vecs[i].at) tick();
      check($sformatf("%s_rst_out@%0d", tag, vecs[i].at), 32'(rst_out), 32'(vecs[i].ro));
      check($sformatf("%s_done@%0d", tag, vecs[i].at), 32'(done), 32'(vecs[i].dn));
    end
    check({tag, "_cause"}, 32'(rst_cause), 32'(cause));
    check({tag, "_sw_cnt"}, 32'(sw_cnt), 32'(swc));
  endtask

  task automatic pulse_req(input int n);
    sw_rst_req = 1'b1;
    repeat (n) tick();
    sw_rst_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hold_bad;
    int last;

    vecs[0] = '{at: -1, ro: 3'b111, dn: 1'b0};
    vecs[1] = '{at:  0, ro: 3'b110, dn: 1'b0};
    vecs[2] = '{at:  3, ro: 3'b110, dn: 1'b0};
    vecs[3] = '{at:  4, ro: 3'b100, dn: 1'b0};
    vecs[4] = '{at:  7, ro: 3'b100, dn: 1'b0};
    vecs[5] = '{at:  8, ro: 3'b000, dn: 1'b1};
    vecs[6] = '{at: 12, ro: 3'b000, dn: 1'b1};

    // Power-on: state while reset held low.
    repeat (3) tick();
    check("por_rst_out", 32'(rst_out), 32'h7);
    check("por_done", 32'(done), 32'h0);
    check("por_cause", 32'(rst_cause), 32'h1);
    check("por_sw_cnt", 32'(sw_cnt), 32'h0);
    #4 reset = 1'b1;
    pos = -1;
    tick();  // edge 0
    check("edge0_rst_out", 32'(rst_out), 32'h7);
    play("por", 17, 2'b01, 0);

    // Single soft request in RUN.
    pulse_req(REQ_LEN);
    exp_swc++;
    check("soft_rst_out", 32'(rst_out), 32'h7);
    check("soft_done", 32'(done), 32'h0);
    check("soft_cause", 32'(rst_cause), 32'h2);
    check("soft_sw_cnt", 32'(sw_cnt), 32'(exp_swc));
    play("soft", pos + 16, 2'b10, exp_swc);

    // Request held high for 50 cycles: one count, outputs held in reset.
    sw_rst_req = 1'b1;
    repeat (REQ_LEN) tick();
    exp_swc++;
    check("hold_first_sw_cnt", 32'(sw_cnt), 32'(exp_swc));
    hold_bad = 0;
    for (int i = REQ_LEN; i < 50; i++) begin
      tick();
      if (rst_out !== 3'b111) hold_bad++;
    end
    sw_rst_req = 1'b0;
    check("hold_rst_out_glitches", 32'(hold_bad), 32'h0);
    check("hold_sw_cnt", 32'(sw_cnt), 32'(exp_swc));
    play("hold", pos + 16, 2'b10, exp_swc);

`ifdef RST_SEQ_DEBOUNCE_EN
    // Debounce: a 3-sample burst is rejected, a 4-sample burst accepted.
    pulse_req(3);
    tick();
    check("deb_short_rst_out", 32'(rst_out), 32'h0);
    check("deb_short_sw_cnt", 32'(sw_cnt), 32'(exp_swc));
    pulse_req(4);
    exp_swc++;
    check("deb_long_rst_out", 32'(rst_out), 32'h7);
    check("deb_long_sw_cnt", 32'(sw_cnt), 32'(exp_swc));
    play("deb", pos + 16, 2'b10, exp_swc);
`endif

    // 300 requests, each accepted on entry to RELEASE: sw_cnt saturates.
    for (int i = 0; i < 300; i++) begin
      pulse_req(REQ_LEN);
      if (exp_swc < 255) exp_swc++;
      check($sformatf("sat_sw_cnt_%0d", i), 32'(sw_cnt), 32'(exp_swc));
      repeat (16) tick();
    end
    check("sat_final_sw_cnt", 32'(sw_cnt), 32'd255);
    check("sat_in_release", 32'(rst_out), 32'h6);

    // Short async reset pulse between edges during RELEASE.
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst_out", 32'(rst_out), 32'h7);
    check("async_done", 32'(done), 32'h0);
    check("async_cause", 32'(rst_cause), 32'h1);
    check("async_sw_cnt", 32'(sw_cnt), 32'h0);
    #2 reset = 1'b1;
    pos = -1;
    tick();  // edge 0
    check("async_edge0_rst_out", 32'(rst_out), 32'h7);
    play("async", 17, 2'b01, 0);

    last = n_cmp;
    if (last == 0) $display("FAIL no_checks: got 0, expected >0");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in the reset-release synchronizer (legal range 2..4).
REQ-002 Parameter STRETCH, default 16, SHALL set the cycles all outputs stay in reset after synchronized release (legal range 1..255).
REQ-003 Parameter GAP, default 4, SHALL set the cycles between successive output-reset releases (legal range 1..255).
REQ-004 Parameter DEB_LEN, default 4, SHALL set the consecutive high samples that qualify a soft request when debounce is compiled in (legal range 2..15).
REQ-005 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the power-on reset, asynchronous and active-low.
REQ-007 Port sw_rst_req, input, 1, SHALL be a synchronous level-sensitive soft-reset request, active-high.
REQ-008 Port rst_out, output, 3, SHALL carry active-high resets for three downstream stages; rst_out[0] releases first.
REQ-009 Port done, output, 1, SHALL be high only when all rst_out bits are low.
REQ-010 Port rst_cause, output, 2, SHALL hold the cause of the last reset: 01 = power-on, 10 = soft.
REQ-011 Port sw_cnt, output, 8, SHALL count accepted soft resets.

Function
REQ-012 The FSM SHALL have states ASSERT, RELEASE and RUN, with ASSERT as the reset state.
REQ-013 In ASSERT, the FSM SHALL hold rst_out=3'b111, count STRETCH synchronized cycles, then go to RELEASE.
REQ-014 In RELEASE, the FSM SHALL clear rst_out[0] on entry, rst_out[1] GAP edges later and rst_out[2] GAP edges after that, then enter RUN on the edge rst_out[2] falls.
REQ-015 Timing SHALL be counted from edge 0, the first rising edge with reset high: rst_out[0] falls at edge SYNC_STAGES+STRETCH-1, rst_out[1] at that edge+GAP, rst_out[2] and done-rise at that edge+2*GAP.
REQ-016 An accepted soft request in RELEASE or RUN SHALL, on the next rising edge, set rst_out=3'b111, clear done, set rst_cause=10, increment sw_cnt and enter ASSERT with the counter cleared.
REQ-017 While sw_rst_req stays high in ASSERT, the stretch counter SHALL be held at 0, so release starts STRETCH cycles after the request drops.
REQ-018 Soft requests held high across the entry to ASSERT SHALL count once; a new request SHALL require a low sample first.
REQ-019 sw_cnt SHALL saturate at 255 and SHALL be cleared only by reset.
REQ-020 rst_out bits SHALL only ever deassert in index order and SHALL never glitch low while the FSM is in ASSERT.

Reset
REQ-021 reset low SHALL asynchronously force rst_out=3'b111, done=0, rst_cause=01, sw_cnt=0, all synchronizer flops to 0, and the FSM to ASSERT with the counter at 0.
REQ-022 reset deassertion SHALL reach the FSM only through the SYNC_STAGES-flop synchronizer.
REQ-023 reset asserted mid-RELEASE or mid-RUN SHALL re-enter ASSERT immediately, with no clock edge required.

Configuration
REQ-024 With macro RST_SEQ_DEBOUNCE_EN defined, a soft request SHALL be accepted only after DEB_LEN consecutive high samples, and the debounce counter SHALL clear on any low sample.
REQ-025 Without RST_SEQ_DEBOUNCE_EN, a single high sample SHALL be accepted, and no debounce counter logic SHALL be present.

Verification
REQ-026 Default parameters, reset released before edge 0 -> rst_out[0] falls at edge 17, rst_out[1] at edge 21, rst_out[2] and done rise at edge 25, rst_cause=01.
REQ-027 In RUN, sw_rst_req high for 1 cycle (no debounce) -> next edge rst_out=111, done=0, rst_cause=10, sw_cnt=1; the release sequence repeats with 16/4/4 spacing after the request drops.
REQ-028 reset pulsed low for 3 ns between clock edges during RELEASE -> rst_out=111 immediately, sw_cnt=0, rst_cause=01, full sequence restarts.
REQ-029 RST_SEQ_DEBOUNCE_EN defined, DEB_LEN=4, sw_rst_req high 3 cycles, low 1, high 4 -> only the 4-cycle burst is accepted, sw_cnt=1.
REQ-030 Issue 300 soft requests -> sw_cnt stops at 255; sw_rst_req held high 50 cycles -> sw_cnt increments once and rst_out stays 111 throughout.
